// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for mont_mul: issues one Montgomery
// product at a time over the start/done handshake, operands referenced by address.
module mont_exp_ctrl #(
  parameter int EXP_BITS = 32,
  parameter int SKIP_LZ  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [EXP_BITS-1:0] exp,
  input  logic [31:0]         base_addr,
  input  logic [31:0]         one_addr,
  input  logic [31:0]         n_addr,
  input  logic [31:0]         res_addr,
  output logic                busy,
  output logic                done,
  output logic [15:0]         op_count,
  output logic                mm_start,
  output logic [31:0]         mm_a_addr,
  output logic [31:0]         mm_b_addr,
  output logic [31:0]         mm_n_addr,
  output logic [31:0]         mm_res_addr,
  input  logic                mm_done
);

  localparam int IW = $clog2(EXP_BITS);
  localparam logic [IW-1:0] IDX_TOP = IW'(EXP_BITS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, WAIT, SCAN, DONE} state_t;
  typedef enum logic [1:0] {OP_INIT, OP_SQR, OP_MUL} op_t;

  state_t              state;
  op_t                 op;
  op_t                 nxt_op;
  logic [EXP_BITS-1:0] exp_q;
  logic [31:0]         base_q;
  logic [31:0]         res_q;
  logic [IW-1:0]       idx;
  logic                seen;
  logic                cur_bit;
  logic                last_bit;
  logic                nxt_issue;
  logic                nxt_finish;
  logic                nxt_scan;
  logic                idx_dec;
  logic                set_seen;

  assign cur_bit  = exp_q[idx];
  assign last_bit = (idx == '0);

  // Next-step decision, evaluated when an op completes or while scanning for the leading one.
  always_comb begin
    nxt_issue  = 1'b0;
    nxt_op     = OP_SQR;
    nxt_finish = 1'b0;
    nxt_scan   = 1'b0;
    idx_dec    = 1'b0;
    set_seen   = 1'b0;
    case (state)
      WAIT: begin
        if (mm_done) begin
          unique case (op)
            OP_INIT: begin
              if ((SKIP_LZ != 0) && !seen) nxt_scan = 1'b1;
              else                         nxt_issue = 1'b1;
            end
            OP_SQR: begin
              if (cur_bit) begin
                nxt_issue = 1'b1;
                nxt_op    = OP_MUL;
              end else if (last_bit) begin
                nxt_finish = 1'b1;
              end else begin
                idx_dec   = 1'b1;
                nxt_issue = 1'b1;
              end
            end
            OP_MUL: begin
              if (last_bit) begin
                nxt_finish = 1'b1;
              end else begin
                idx_dec   = 1'b1;
                nxt_issue = 1'b1;
              end
            end
            default: nxt_finish = 1'b1;
          endcase
        end
      end
      SCAN: begin
        // The accumulator is still Montgomery 1 here, so the leading bit needs only the multiply.
        if (cur_bit) begin
          set_seen  = 1'b1;
          nxt_issue = 1'b1;
          nxt_op    = OP_MUL;
        end else if (last_bit) begin
          nxt_finish = 1'b1;
        end else begin
          idx_dec  = 1'b1;
          nxt_scan = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op          <= OP_INIT;
      exp_q       <= '0;
      base_q      <= '0;
      res_q       <= '0;
      idx         <= IDX_TOP;
      seen        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      op_count    <= '0;
      mm_start    <= 1'b0;
      mm_a_addr   <= '0;
      mm_b_addr   <= '0;
      mm_n_addr   <= '0;
      mm_res_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q       <= exp;
            base_q      <= base_addr;
            res_q       <= res_addr;
            op          <= OP_INIT;
            op_count    <= '0;
            seen        <= 1'b0;
            idx         <= IDX_TOP;
            busy        <= 1'b1;
            mm_start    <= 1'b1;
            mm_a_addr   <= one_addr;
            mm_b_addr   <= one_addr;
            mm_n_addr   <= n_addr;
            mm_res_addr <= res_addr;
            state       <= ISSUE0;
          end
        end
        ISSUE0: begin
          if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
          state <= ISSUE1;
        end
        ISSUE1: begin
          mm_start <= 1'b0;
          state    <= WAIT;
        end
        WAIT, SCAN: begin
          if (idx_dec)  idx  <= idx - 1'b1;
          if (set_seen) seen <= 1'b1;
          if (nxt_issue) begin
            op        <= nxt_op;
            mm_a_addr <= res_q;
            mm_b_addr <= (nxt_op == OP_MUL) ? base_q : res_q;
            mm_start  <= 1'b1;
            state     <= ISSUE0;
          end else if (nxt_finish) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (nxt_scan) begin
            state <= SCAN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: one instance per SKIP_LZ setting, a mont_mul + memory model
// with random latency, and expected results from plain modular arithmetic.
module tb_mont_exp_ctrl;

  localparam int              EB    = 4;
  localparam longint unsigned NMOD  = 64'd65521;
  localparam longint unsigned RMOD  = 64'd65536 % NMOD;
  localparam int              K_INIT = 0;
  localparam int              K_SQR  = 1;
  localparam int              K_MUL  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_s     [2];
  logic [3:0]  exp_s       [2];
  logic [31:0] base_addr_s [2];
  logic [31:0] one_addr_s  [2];
  logic [31:0] n_addr_s    [2];
  logic [31:0] res_addr_s  [2];
  logic        busy_s      [2];
  logic        done_s      [2];
  logic [15:0] op_count_s  [2];
  logic        mm_start_s  [2];
  logic [31:0] mm_a_s      [2];
  logic [31:0] mm_b_s      [2];
  logic [31:0] mm_n_s      [2];
  logic [31:0] mm_r_s      [2];
  logic        mm_done_s   [2];

  for (genvar g = 0; g < 2; g++) begin : inst
    mont_exp_ctrl #(.EXP_BITS(EB), .SKIP_LZ(g)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_s[g]),
      .exp        (exp_s[g]),
      .base_addr  (base_addr_s[g]),
      .one_addr   (one_addr_s[g]),
      .n_addr     (n_addr_s[g]),
      .res_addr   (res_addr_s[g]),
      .busy       (busy_s[g]),
      .done       (done_s[g]),
      .op_count   (op_count_s[g]),
      .mm_start   (mm_start_s[g]),
      .mm_a_addr  (mm_a_s[g]),
      .mm_b_addr  (mm_b_s[g]),
      .mm_n_addr  (mm_n_s[g]),
      .mm_res_addr(mm_r_s[g]),
      .mm_done    (mm_done_s[g])
    );
  end

  int checks = 0;
  int errors = 0;

  longint unsigned mem  [bit [31:0]];
  longint unsigned wmem [bit [31:0]];
  longint unsigned rinv;
  longint unsigned cur_b;
  logic [31:0] cur_one, cur_base, cur_n, cur_res;
  logic [3:0]  cur_exp;
  int          run_id = 0;
  int          ops_base;
  bit          spurious = 1'b0;
  int          lat_lo = 3;
  int          lat_hi = 50;

  int  kinds [$];
  int  slens [$];
  bit  unsts [$];
  bit  nroks [$];

  int          mphase [2];
  int          mcnt   [2];
  int          mslen  [2];
  bit          munst  [2];
  logic [31:0] ma [2];
  logic [31:0] mb [2];
  logic [31:0] mn [2];
  logic [31:0] mr [2];

  function automatic longint unsigned rd(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    if (mem.exists(a))  return mem[a];
    return 64'd0;
  endfunction

  function automatic longint unsigned mont(input longint unsigned a, input longint unsigned b,
                                           input longint unsigned n);
    if (n != NMOD) return 64'd0;
    return ((a * b) % NMOD) * rinv % NMOD;
  endfunction

  function automatic int kind_of(input logic [31:0] a, input logic [31:0] b);
    if (a == cur_one && b == cur_one)  return K_INIT;
    if (a == cur_res && b == cur_res)  return K_SQR;
    if (a == cur_res && b == cur_base) return K_MUL;
    return 3;
  endfunction

  function automatic bit moved(input int g);
    return (mm_a_s[g] !== ma[g]) || (mm_b_s[g] !== mb[g]) ||
           (mm_n_s[g] !== mn[g]) || (mm_r_s[g] !== mr[g]);
  endfunction

  // mont_mul stand-in: grabs operands at mm_start, answers after a random latency.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        mm_done_s[g] = 1'b0;
        mphase[g]    = 0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        mm_done_s[g] = 1'b0;
        case (mphase[g])
          0: begin
            if (mm_start_s[g] === 1'b1) begin
              ma[g] = mm_a_s[g];
              mb[g] = mm_b_s[g];
              mn[g] = mm_n_s[g];
              mr[g] = mm_r_s[g];
              mslen[g]     = 1;
              munst[g]     = 1'b0;
              mphase[g]    = 1;
              mm_done_s[g] = spurious;
            end
          end
          1: begin
            if (mm_start_s[g] === 1'b1) mslen[g]++;
            if (moved(g)) munst[g] = 1'b1;
            mcnt[g]      = int'($urandom_range(lat_hi, lat_lo));
            mphase[g]    = 2;
            mm_done_s[g] = spurious;
          end
          default: begin
            if (mm_start_s[g] === 1'b1) mslen[g]++;
            if (moved(g)) munst[g] = 1'b1;
            mcnt[g]--;
            if (mcnt[g] == 0) begin
              wmem[mr[g]] = mont(rd(ma[g]), rd(mb[g]), rd(mn[g]));
              kinds.push_back(kind_of(ma[g], mb[g]));
              slens.push_back(mslen[g]);
              unsts.push_back(munst[g]);
              nroks.push_back((mn[g] == cur_n) && (mr[g] == cur_res));
              mm_done_s[g] = 1'b1;
              mphase[g]    = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic longint unsigned powmod(input longint unsigned b, input logic [3:0] e);
    longint unsigned r = 64'd1;
    for (int i = 0; i < int'(e); i++) r = (r * b) % NMOD;
    return r;
  endfunction

  task automatic setup_run(input int g, input logic [3:0] e, input bit noisy);
    run_id++;
    cur_exp  = e;
    cur_b    = longint'($urandom_range(32'(NMOD - 1), 1));
    cur_one  = 32'h0100 + (32'($urandom_range(15, 0)) << 4);
    cur_base = 32'h1000 + (32'($urandom_range(15, 0)) << 4);
    cur_n    = 32'h2000 + (32'($urandom_range(15, 0)) << 4);
    cur_res  = 32'h3000 + (32'(run_id) << 4);
    mem[cur_one]  = RMOD;
    mem[cur_base] = (cur_b * RMOD) % NMOD;
    mem[cur_n]    = NMOD;
    mem[cur_res]  = longint'($urandom_range(32'(NMOD - 1), 0));
    spurious       = noisy;
    ops_base       = kinds.size();
    exp_s[g]       = e;
    base_addr_s[g] = cur_base;
    one_addr_s[g]  = cur_one;
    n_addr_s[g]    = cur_n;
    res_addr_s[g]  = cur_res;
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    start_s[g] = 1'b1;
    @(negedge clk);
    start_s[g] = 1'b0;
    check_output("busy_after_start", busy_s[g], 1);
    check_output("op_count_cleared", op_count_s[g], 0);
  endtask

  // One complete exponentiation, with optional start/port noise and spurious mm_done.
  task automatic apply_stimulus(input int g, input logic [3:0] e, input bit noisy);
    int  eseq [$];
    int  msb = -1;
    int  pop = 0;
    int  top;
    int  cyc = 0;
    int  gaps = 0;
    int  n_obs;
    bit  done_seen = 1'b0;
    longint unsigned exp_cnt;
    setup_run(g, e, noisy);
    pulse_start(g);
    while (!done_seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done_s[g] === 1'b1) begin
        done_seen = 1'b1;
      end else begin
        if (busy_s[g] !== 1'b1) gaps++;
        if (noisy) begin
          start_s[g]     = 1'($urandom);
          exp_s[g]       = 4'($urandom);
          base_addr_s[g] = $urandom;
        end
      end
    end
    check_output("done_within_budget", done_seen, 1);
    check_output("busy_low_at_done", busy_s[g], 0);
    check_output("busy_gaps", gaps, 0);
    start_s[g] = noisy;
    @(negedge clk);
    start_s[g]     = 1'b0;
    exp_s[g]       = cur_exp;
    base_addr_s[g] = cur_base;
    check_output("done_one_cycle", done_s[g], 0);
    check_output("idle_after_done", busy_s[g], 0);
    @(negedge clk);
    check_output("no_restart_from_done", mm_start_s[g], 0);

    for (int i = 0; i < EB; i++) if (e[i]) begin msb = i; pop++; end
    eseq.push_back(K_INIT);
    top = (g != 0) ? msb : EB - 1;
    for (int i = top; i >= 0; i--) begin
      if (!(g != 0 && i == msb)) eseq.push_back(K_SQR);
      if (e[i]) eseq.push_back(K_MUL);
    end
    if (g == 0)      exp_cnt = 64'(1 + EB + pop);
    else if (e != 0) exp_cnt = 64'(1 + msb + pop);
    else             exp_cnt = 64'd1;

    n_obs = kinds.size() - ops_base;
    check_output("op_count", op_count_s[g], exp_cnt);
    check_output("ops_issued", n_obs, eseq.size());
    for (int i = 0; i < n_obs && i < eseq.size(); i++) begin
      check_output("op_kind", kinds[ops_base + i], eseq[i]);
      check_output("mm_start_cycles", slens[ops_base + i], 2);
      check_output("addr_unstable", unsts[ops_base + i], 0);
      check_output("n_res_addr", nroks[ops_base + i], 1);
    end
    check_output("result", rd(cur_res), (powmod(cur_b, e) * RMOD) % NMOD);
  endtask

  initial begin
    bit reached = 1'b0;
    for (longint unsigned x = 1; x < NMOD; x++) if ((RMOD * x) % NMOD == 1) rinv = x;
    for (int g = 0; g < 2; g++) begin
      start_s[g]     = 1'b0;
      exp_s[g]       = '0;
      base_addr_s[g] = '0;
      one_addr_s[g]  = '0;
      n_addr_s[g]    = '0;
      res_addr_s[g]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_output("rst_busy", busy_s[g], 0);
      check_output("rst_done", done_s[g], 0);
      check_output("rst_op_count", op_count_s[g], 0);
      check_output("rst_mm_start", mm_start_s[g], 0);
      check_output("rst_addrs", {mm_a_s[g] | mm_b_s[g] | mm_n_s[g] | mm_r_s[g]}, 0);
    end
    rst_n = 1'b1;

    apply_stimulus(1, 4'b0000, 1'b0);
    apply_stimulus(0, 4'b1011, 1'b0);
    apply_stimulus(1, 4'b1011, 1'b0);
    apply_stimulus(1, 4'($urandom), 1'b1);
    apply_stimulus(0, 4'($urandom), 1'b1);
    apply_stimulus(1, 4'b0001, 1'b0);

    // Abort in the WAIT of the third op, then a clean rerun.
    lat_lo = 10;
    setup_run(1, 4'b1011, 1'b0);
    pulse_start(1);
    for (int c = 0; c < 3000 && !reached; c++) begin
      @(negedge clk);
      if (kinds.size() - ops_base == 2 && mphase[1] == 2) reached = 1'b1;
    end
    check_output("abort_reached_op3", reached, 1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_output("abort_busy", busy_s[1], 0);
    check_output("abort_done", done_s[1], 0);
    check_output("abort_mm_start", mm_start_s[1], 0);
    check_output("abort_op_count", op_count_s[1], 0);
    rst_n  = 1'b1;
    lat_lo = 3;
    apply_stimulus(1, 4'b1011, 1'b0);

    for (int i = 0; i < 6; i++) apply_stimulus(i % 2, 4'($urandom), i >= 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
